pipe_regfile: RTL

PIPE_REGFILE -- requirements
Module: pipe_regfile

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_scoreboard.sv | 83 ++++++++
 rtl/pipe_regfile.sv | 87 ++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared sizing constants and the write-back hit helper for the pipelined register file.
package pipe_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned CNT_W      = 2;

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

   // True when a write-back in flight this cycle targets addr (never for r0).
   function automatic logic wb_hit(input logic [REG_ADDR_W-1:0] addr,
                                   input logic                  wena,
                                   input logic [REG_ADDR_W-1:0] waddr);
      return wena && (waddr != ZERO_REG) && (addr == waddr);
   endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Per-register pending-write counters with source busy, issue stall and sticky underflow flag.
module pipe_scoreboard
   import pipe_pkg::REG_ADDR_W, pipe_pkg::ZERO_REG, pipe_pkg::wb_hit;
#(
   parameter int unsigned NUM_REGS = pipe_pkg::NUM_REGS,
   parameter int unsigned CNT_W    = pipe_pkg::CNT_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] wb_rd_waddr,
   input  logic                  wb_rd_wena,
   input  logic [REG_ADDR_W-1:0] rs_raddr,
   input  logic [REG_ADDR_W-1:0] rt_raddr,
   input  logic                  rs_used,
   input  logic                  rt_used,
   input  logic                  iss_valid,
   input  logic [REG_ADDR_W-1:0] iss_rd_waddr,
   input  logic                  iss_rd_wena,
   output logic                  rs_busy,
   output logic                  rt_busy,
   output logic                  stall,
   output logic                  sb_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q [NUM_REGS];
   logic [CNT_W-1:0] cnt_d [NUM_REGS];
   logic             sb_err_q, sb_err_d;

   logic [CNT_W-1:0] rs_cnt, rt_cnt, dest_cnt;
   logic             dest_full, wb_dec, iss_inc;

   // A producer writing back this cycle no longer blocks its consumers.
   always_comb begin : busy_stall
      rs_cnt    = cnt_q[rs_raddr];
      rt_cnt    = cnt_q[rt_raddr];
      dest_cnt  = cnt_q[iss_rd_waddr];
      rs_busy   = (rs_raddr != ZERO_REG) && (rs_cnt != '0) &&
                  !(wb_hit(rs_raddr, wb_rd_wena, wb_rd_waddr) && (rs_cnt == CNT_ONE));
      rt_busy   = (rt_raddr != ZERO_REG) && (rt_cnt != '0) &&
                  !(wb_hit(rt_raddr, wb_rd_wena, wb_rd_waddr) && (rt_cnt == CNT_ONE));
      dest_full = iss_rd_wena && (iss_rd_waddr != ZERO_REG) && (dest_cnt == CNT_MAX) &&
                  !wb_hit(iss_rd_waddr, wb_rd_wena, wb_rd_waddr);
      stall     = iss_valid && ((rs_used && rs_busy) || (rt_used && rt_busy) || dest_full);
   end

   always_comb begin : cnt_next
      cnt_d    = cnt_q;
      sb_err_d = sb_err_q;
      wb_dec   = wb_rd_wena && (wb_rd_waddr != ZERO_REG);
      iss_inc  = iss_valid && !stall && iss_rd_wena && (iss_rd_waddr != ZERO_REG);
      if (wb_dec && (cnt_q[wb_rd_waddr] == '0)) begin
         sb_err_d = 1'b1;
      end
      // Matching increment and decrement on one register cancel out.
      if (!(iss_inc && wb_dec && (iss_rd_waddr == wb_rd_waddr))) begin
         if (iss_inc) begin
            cnt_d[iss_rd_waddr] = cnt_q[iss_rd_waddr] + CNT_ONE;
         end
         if (wb_dec && (cnt_q[wb_rd_waddr] != '0)) begin
            cnt_d[wb_rd_waddr] = cnt_q[wb_rd_waddr] - CNT_ONE;
         end
      end
      cnt_d[0] = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            cnt_q[i] <= '0;
         end
         sb_err_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         sb_err_q <= sb_err_d;
      end
   end

   assign sb_err = sb_err_q;

endmodule

// File: rtl/pipe_regfile.sv
// Architectural register file with write-through bypass and an issue scoreboard.
module pipe_regfile
   import pipe_pkg::REG_ADDR_W, pipe_pkg::ZERO_REG, pipe_pkg::wb_hit;
#(
   parameter int unsigned DATA_W   = pipe_pkg::DATA_W,
   parameter int unsigned NUM_REGS = pipe_pkg::NUM_REGS,
   parameter int unsigned CNT_W    = pipe_pkg::CNT_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] wb_rd_waddr,
   input  logic                  wb_rd_wena,
   input  logic [DATA_W-1:0]     wb_rd_wdata,
   input  logic [REG_ADDR_W-1:0] rs_raddr,
   input  logic [REG_ADDR_W-1:0] rt_raddr,
   input  logic                  rs_used,
   input  logic                  rt_used,
   output logic [DATA_W-1:0]     rs_rdata,
   output logic [DATA_W-1:0]     rt_rdata,
   input  logic                  iss_valid,
   input  logic [REG_ADDR_W-1:0] iss_rd_waddr,
   input  logic                  iss_rd_wena,
   output logic                  rs_busy,
   output logic                  rt_busy,
   output logic                  stall,
   output logic                  sb_err
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];

   // Reset masks the bypass path so reads stay zero while rst_n is low.
   function automatic logic [DATA_W-1:0] read_port(input logic [REG_ADDR_W-1:0] addr);
      if (!rst_n || (addr == ZERO_REG)) begin
         return '0;
      end else if (wb_hit(addr, wb_rd_wena, wb_rd_waddr)) begin
         return wb_rd_wdata;
      end else begin
         return regs_q[addr];
      end
   endfunction

   always_comb begin : reg_next
      regs_d = regs_q;
      if (wb_rd_wena && (wb_rd_waddr != ZERO_REG)) begin
         regs_d[wb_rd_waddr] = wb_rd_wdata;
      end
      regs_d[0] = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin : read_ports
      rs_rdata = read_port(rs_raddr);
      rt_rdata = read_port(rt_raddr);
   end

   pipe_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .CNT_W    (CNT_W)
   ) u_scoreboard (
      .clk          (clk),
      .rst_n        (rst_n),
      .wb_rd_waddr  (wb_rd_waddr),
      .wb_rd_wena   (wb_rd_wena),
      .rs_raddr     (rs_raddr),
      .rt_raddr     (rt_raddr),
      .rs_used      (rs_used),
      .rt_used      (rt_used),
      .iss_valid    (iss_valid),
      .iss_rd_waddr (iss_rd_waddr),
      .iss_rd_wena  (iss_rd_wena),
      .rs_busy      (rs_busy),
      .rt_busy      (rt_busy),
      .stall        (stall),
      .sb_err       (sb_err)
   );

endmodule
